run_length_encode_p: RTL and testbench
======================================

RUN_LENGTH_ENCODE_P -- requirements
Module: run_length_encode_p

Interface
REQ-001 SHALL have parameter DATA_W, default 16: pixel and output word width.
REQ-002 SHALL have parameter PIXEL_COUNT, default 1600: pixels per frame; legal range 1..2^16-1.
REQ-003 SHALL have parameter MAX_RUN, default 2^DATA_W-1: longest run emitted as one token; legal range 2..2^DATA_W-1.
REQ-004 SHALL have ports in this order: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have ports in_data input DATA_W (pixel); in_avail input 1 (pixel present); in_read output 1 (pixel consumed this cycle).
REQ-006 SHALL have ports out_data output DATA_W (token); out_write output 1 (token valid); out_full input 1 (sink cannot accept).
REQ-007 SHALL have ports running output 1 (not starved) and frame_done output 1 (one-cycle end-of-frame pulse).

Function
REQ-008 SHALL emit zero runs as marker word 0 followed by the run-length word, and each nonzero pixel as one literal word.
REQ-009 SHALL use states FETCH, CLASSIFY, MARK, CNT, LIT, ENDCHK, FLUSH.
REQ-010 FETCH: in_read = in_avail combinationally; on accept, latch in_data, pix_idx+1, go to CLASSIFY.
REQ-011 CLASSIFY: zero and not in_run -> MARK; zero and in_run -> run_cnt+1, then CNT if the new count equals MAX_RUN, else ENDCHK; nonzero and in_run -> CNT with literal pending; nonzero and not in_run -> LIT.
REQ-012 MARK: write 0, set in_run=1 and run_cnt=1, go to ENDCHK.
REQ-013 CNT: write run_cnt, clear in_run and run_cnt, go to LIT if a literal is pending, else ENDCHK.
REQ-014 LIT: write the literal register, go to ENDCHK.
REQ-015 ENDCHK: if pix_idx==PIXEL_COUNT, clear pix_idx, then go to FLUSH if in_run, else pulse frame_done and go to FETCH; otherwise go to FETCH.
REQ-016 FLUSH: write run_cnt, clear in_run and run_cnt, pulse frame_done, go to FETCH.
REQ-017 Write states SHALL drive out_write = !out_full and SHALL hold state, registers and out_data stable while out_full=1.
REQ-018 out_data SHALL be 0 in all non-write states; at most one token per cycle.
REQ-019 running SHALL equal in_avail in FETCH and 1 in all other states.
REQ-020 run_cnt SHALL never exceed MAX_RUN; a saturated run closes, and the next zero starts a new marker.
REQ-021 pix_idx SHALL count 0..PIXEL_COUNT and wrap to 0 at each frame end.

Reset
REQ-022 On rst, state SHALL be FETCH; pix_idx, run_cnt, in_run, the pending flag and the literal register SHALL be 0.
REQ-023 During and after rst, in_read, out_write, frame_done and out_data SHALL be 0, and running SHALL be 1.
REQ-024 Mid-frame rst SHALL discard any open run without emitting it, and the next accepted pixel SHALL be pixel 0 of a new frame.

Configuration
REQ-025 With RLE_SQUARE_EN defined, the literal SHALL be the low DATA_W bits of pixel*pixel, registered in CLASSIFY with no extra cycle.
REQ-026 Without RLE_SQUARE_EN, the literal SHALL be the pixel unchanged and no multiplier SHALL be instantiated.

Structure
REQ-027 A shared package rle_pkg SHALL hold the state enum, the zero-marker constant and the default parameter constants.
REQ-028 The squaring datapath SHALL be a sub-module rle_square (DATA_W parameter, combinational low-half product), instantiated only under RLE_SQUARE_EN.

Verification
REQ-029 PIXEL_COUNT=8, RLE_SQUARE_EN on, frame [3,0,0,0,5,0,0,2] -> tokens 9,0,3,25,0,2,4; one frame_done pulse after the last token.
REQ-030 MAX_RUN=4, frame of 8 zeros -> tokens 0,4,0,4; no FLUSH token; frame_done pulse.
REQ-031 RLE_SQUARE_EN off, PIXEL_COUNT=8, frame [1,0,0,0,0,0,0,0] -> tokens 1,0,7, with 7 written in FLUSH together with frame_done.
REQ-032 out_full held high 5 cycles while in CNT -> out_write low and out_data held at the count for those cycles; token sequence unchanged after release.
REQ-033 rst asserted after 3 zeros of a frame -> no count token emitted; the next frame [2,...] starts at pix_idx 0 with literal 4 (square on).
REQ-034 in_avail low 10 cycles in FETCH -> in_read 0, running 0, no tokens; resumes on the cycle in_avail rises.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder: FSM state encoding,
// zero-run marker word and default parameter values.
package rle_pkg;

    typedef enum logic [2:0] {
        FETCH,
        CLASSIFY,
        MARK,
        CNT,
        LIT,
        ENDCHK,
        FLUSH
    } rle_state_t;

    localparam int RLE_DEF_DATA_W      = 16;
    localparam int RLE_DEF_PIXEL_COUNT = 1600;

    // Pixel index width; covers frames up to 2^16-1 pixels.
    localparam int RLE_IDX_W = 16;

    // Word written ahead of every zero-run length.
    localparam int RLE_ZERO_MARK = 0;

    // Default longest run: all-ones in a DATA_W word.
    function automatic int rle_def_max_run(input int data_w);
        return (1 << data_w) - 1;
    endfunction

endpackage

// File: rtl/rle_square.sv
// Combinational squarer for the literal path: low DATA_W bits of pixel*pixel.
// Only instantiated when the encoder is built with RLE_SQUARE_EN.
module rle_square #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] pixel,
    output logic [DATA_W-1:0] square
);

    // Product evaluated in DATA_W context keeps only the low half.
    assign square = pixel * pixel;

endmodule

// File: rtl/run_length_encode_p.sv
// run_length_encode_p: zero-run-length encoder for a pixel stream.
// A run of zero pixels is sent as marker word 0 followed by the run length;
// every nonzero pixel is sent as one literal word. Runs longer than MAX_RUN
// are split; a run still open at frame end is flushed with frame_done.
// Build option: define RLE_SQUARE_EN to send pixel*pixel (low DATA_W bits)
// as the literal instead of the raw pixel.
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | wait for a pixel; accept it and bump the pixel index
// CLASSIFY | decide marker / run extension / run close / literal
// MARK     | write marker 0, open a run of length 1
// CNT      | write the run length, close the run
// LIT      | write the literal register
// ENDCHK   | detect frame end; flush an open run or pulse frame_done
// FLUSH    | write the trailing run length together with frame_done
module run_length_encode_p
    import rle_pkg::*;
#(
    parameter int DATA_W      = RLE_DEF_DATA_W,
    parameter int PIXEL_COUNT = RLE_DEF_PIXEL_COUNT,
    parameter int MAX_RUN     = rle_def_max_run(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_avail,
    output logic              in_read,
    output logic [DATA_W-1:0] out_data,
    output logic              out_write,
    input  logic              out_full,
    output logic              running,
    output logic              frame_done
);

    localparam logic [DATA_W-1:0]    ZERO_WORD = DATA_W'(RLE_ZERO_MARK);
    localparam logic [DATA_W-1:0]    MAX_RUN_W = DATA_W'(MAX_RUN);
    localparam logic [RLE_IDX_W-1:0] LAST_IDX  = RLE_IDX_W'(PIXEL_COUNT);

    rle_state_t            state, state_n;
    logic [DATA_W-1:0]     pix_reg, pix_reg_n;
    logic [DATA_W-1:0]     lit_reg, lit_reg_n;
    logic                  lit_pend, lit_pend_n;
    logic                  in_run, in_run_n;
    logic [DATA_W-1:0]     run_cnt, run_cnt_n;
    logic [RLE_IDX_W-1:0]  pix_idx, pix_idx_n;
    logic [DATA_W-1:0]     run_cnt_inc;
    logic [DATA_W-1:0]     lit_value;

    assign run_cnt_inc = run_cnt + DATA_W'(1);

`ifdef RLE_SQUARE_EN
    rle_square #(
        .DATA_W (DATA_W)
    ) u_square (
        .pixel  (pix_reg),
        .square (lit_value)
    );
`else
    assign lit_value = pix_reg;
`endif

    // State and datapath registers; synchronous reset drops any open run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pix_reg  <= '0;
            lit_reg  <= '0;
            lit_pend <= 1'b0;
            in_run   <= 1'b0;
            run_cnt  <= '0;
            pix_idx  <= '0;
        end else begin
            state    <= state_n;
            pix_reg  <= pix_reg_n;
            lit_reg  <= lit_reg_n;
            lit_pend <= lit_pend_n;
            in_run   <= in_run_n;
            run_cnt  <= run_cnt_n;
            pix_idx  <= pix_idx_n;
        end
    end

    // Next-state, datapath next values and handshake outputs.
    // Write states only advance when the sink can accept, so every
    // register and out_data stay frozen while out_full is high.
    always_comb begin
        state_n    = state;
        pix_reg_n  = pix_reg;
        lit_reg_n  = lit_reg;
        lit_pend_n = lit_pend;
        in_run_n   = in_run;
        run_cnt_n  = run_cnt;
        pix_idx_n  = pix_idx;
        in_read    = 1'b0;
        out_write  = 1'b0;
        out_data   = '0;
        running    = 1'b1;
        frame_done = 1'b0;

        case (state)
            FETCH: begin
                running = in_avail;
                in_read = in_avail;
                if (in_avail) begin
                    pix_reg_n = in_data;
                    pix_idx_n = pix_idx + RLE_IDX_W'(1);
                    state_n   = CLASSIFY;
                end
            end

            CLASSIFY: begin
                if (pix_reg == '0) begin
                    if (!in_run) begin
                        state_n = MARK;
                    end else begin
                        // A run reaching MAX_RUN is closed at once so the
                        // counter can never pass the limit.
                        run_cnt_n = run_cnt_inc;
                        state_n   = (run_cnt_inc == MAX_RUN_W) ? CNT : ENDCHK;
                    end
                end else begin
                    lit_reg_n = lit_value;
                    if (in_run) begin
                        lit_pend_n = 1'b1;
                        state_n    = CNT;
                    end else begin
                        state_n = LIT;
                    end
                end
            end

            MARK: begin
                out_data  = ZERO_WORD;
                out_write = !out_full;
                if (!out_full) begin
                    in_run_n  = 1'b1;
                    run_cnt_n = DATA_W'(1);
                    state_n   = ENDCHK;
                end
            end

            CNT: begin
                out_data  = run_cnt;
                out_write = !out_full;
                if (!out_full) begin
                    in_run_n   = 1'b0;
                    run_cnt_n  = '0;
                    lit_pend_n = 1'b0;
                    state_n    = lit_pend ? LIT : ENDCHK;
                end
            end

            LIT: begin
                out_data  = lit_reg;
                out_write = !out_full;
                if (!out_full) begin
                    state_n = ENDCHK;
                end
            end

            ENDCHK: begin
                if (pix_idx == LAST_IDX) begin
                    pix_idx_n = '0;
                    if (in_run) begin
                        state_n = FLUSH;
                    end else begin
                        frame_done = 1'b1;
                        state_n    = FETCH;
                    end
                end else begin
                    state_n = FETCH;
                end
            end

            FLUSH: begin
                out_data  = run_cnt;
                out_write = !out_full;
                if (!out_full) begin
                    in_run_n   = 1'b0;
                    run_cnt_n  = '0;
                    frame_done = 1'b1;
                    state_n    = FETCH;
                end
            end

            default: begin
                state_n = FETCH;
            end
        endcase

        // Keep the interface quiet while reset is held.
        if (rst) begin
            in_read    = 1'b0;
            out_write  = 1'b0;
            out_data   = '0;
            frame_done = 1'b0;
            running    = 1'b1;
        end
    end

endmodule

// File: tb/tb_run_length_encode_p.sv
// Bench for run_length_encode_p. Two instances with 8-pixel frames:
// A uses the default MAX_RUN, B uses MAX_RUN=4. A select bit routes the
// pixel source and token monitor to one instance at a time.
module tb_run_length_encode_p;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       in_avail;
    logic       out_full;
    logic [7:0] in_data;

    logic       avail_a, avail_b;
    logic       rd_a, rd_b, ow_a, ow_b, run_a, run_b, fd_a, fd_b;
    logic [7:0] od_a, od_b;
    logic       rd_m, ow_m, run_m, fd_m;
    logic [7:0] od_m;

    assign avail_a = in_avail & ~sel;
    assign avail_b = in_avail & sel;
    assign rd_m    = sel ? rd_b  : rd_a;
    assign ow_m    = sel ? ow_b  : ow_a;
    assign run_m   = sel ? run_b : run_a;
    assign fd_m    = sel ? fd_b  : fd_a;
    assign od_m    = sel ? od_b  : od_a;

    run_length_encode_p #(
        .DATA_W      (8),
        .PIXEL_COUNT (8)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_avail   (avail_a),
        .in_read    (rd_a),
        .out_data   (od_a),
        .out_write  (ow_a),
        .out_full   (out_full),
        .running    (run_a),
        .frame_done (fd_a)
    );

    run_length_encode_p #(
        .DATA_W      (8),
        .PIXEL_COUNT (8),
        .MAX_RUN     (4)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_avail   (avail_b),
        .in_read    (rd_b),
        .out_data   (od_b),
        .out_write  (ow_b),
        .out_full   (out_full),
        .running    (run_b),
        .frame_done (fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] tok_q[$];
    int         done_cnt = 0;
    bit         last_done_w = 1'b0;

    // Token / frame_done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (ow_m) tok_q.push_back(od_m);
            if (fd_m) begin
                done_cnt    <= done_cnt + 1;
                last_done_w <= ow_m;
            end
        end
    end

    typedef struct {
        string            name;
        bit               sel;
        logic [7:0][7:0]  pix;
        int               ntok;
        logic [7:0][7:0]  tok;
        bit               done_w;
        int               idle;
        int               stall_pix;
        int               stall_val;
    } vec_t;

    function automatic int lit(input int p);
`ifdef RLE_SQUARE_EN
        return (p * p) & 255;
`else
        return p;
`endif
    endfunction

    function automatic logic [7:0][7:0] b8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][7:0] r;
        r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
        r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
        return r;
    endfunction

    function automatic vec_t mkv(input string nm, input bit s, input logic [7:0][7:0] px,
                                 input int nt, input logic [7:0][7:0] tk, input bit dw,
                                 input int idle, input int sp, input int sv);
        vec_t v;
        v.name = nm; v.sel = s; v.pix = px; v.ntok = nt; v.tok = tk;
        v.done_w = dw; v.idle = idle; v.stall_pix = sp; v.stall_val = sv;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Present one pixel from posedge+1 until the DUT consumes it.
    task automatic send_pixel(input logic [7:0] p);
        bit ok;
        ok       = 1'b0;
        in_data  = p;
        in_avail = 1'b1;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = rd_m;
            @(posedge clk); #1;
        end
        in_avail = 1'b0;
        in_data  = 8'd0;
        check("accept_pixel", int'(ok), 1);
    endtask

    task automatic run_frame(input vec_t v);
        int base_t, base_d, got, start;
        bit seen;
        sel    = v.sel;
        base_t = tok_q.size();
        base_d = done_cnt;
        start  = 0;
        if (v.idle > 0) begin
            for (int c = 0; c < v.idle; c++) begin
                @(negedge clk);
                check({v.name, " idle in_read"}, int'(rd_m), 0);
                check({v.name, " idle running"}, int'(run_m), 0);
                check({v.name, " idle out_write"}, int'(ow_m), 0);
            end
            @(posedge clk); #1;
            in_data  = v.pix[0];
            in_avail = 1'b1;
            @(negedge clk);
            check({v.name, " resume in_read"}, int'(rd_m), 1);
            check({v.name, " resume running"}, int'(run_m), 1);
            @(posedge clk); #1;
            in_avail = 1'b0;
            start    = 1;
        end
        for (int i = start; i < 8; i++) begin
            if (i == v.stall_pix) out_full = 1'b1;
            send_pixel(v.pix[i]);
            if (i == v.stall_pix) begin
                seen = 1'b0;
                for (int t = 0; t < 10 && !seen; t++) begin
                    @(negedge clk);
                    seen = (int'(od_m) == v.stall_val);
                end
                check({v.name, " stall reached"}, int'(seen), 1);
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    check({v.name, " stall out_write"}, int'(ow_m), 0);
                    check({v.name, " stall out_data"}, int'(od_m), v.stall_val);
                end
                @(posedge clk); #1;
                out_full = 1'b0;
            end
        end
        check({v.name, " early frame_done"}, done_cnt - base_d, 0);
        seen = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            seen = (done_cnt > base_d);
        end
        repeat (4) @(negedge clk);
        check({v.name, " frame_done pulses"}, done_cnt - base_d, 1);
        check({v.name, " done with write"}, int'(last_done_w), int'(v.done_w));
        check({v.name, " token count"}, tok_q.size() - base_t, v.ntok);
        for (int i = 0; i < v.ntok; i++) begin
            got = (base_t + i < tok_q.size()) ? int'(tok_q[base_t + i]) : -1;
            check($sformatf("%s token%0d", v.name, i), got, int'(v.tok[i]));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[9];
        vec_t post_rst;
        int   base_t, base_d;

        vecs[0] = mkv("mix", 0, b8(3,0,0,0,5,0,0,2), 7,
                      b8(lit(3),0,3,lit(5),0,2,lit(2),0), 0, 0, -1, 0);
        vecs[1] = mkv("sat_zeros", 1, b8(0,0,0,0,0,0,0,0), 4,
                      b8(0,4,0,4,0,0,0,0), 0, 0, -1, 0);
        vecs[2] = mkv("flush7", 0, b8(1,0,0,0,0,0,0,0), 3,
                      b8(lit(1),0,7,0,0,0,0,0), 1, 0, -1, 0);
        vecs[3] = mkv("all_lit", 0, b8(1,2,3,4,5,6,7,8), 8,
                      b8(lit(1),lit(2),lit(3),lit(4),lit(5),lit(6),lit(7),lit(8)), 0, 0, -1, 0);
        vecs[4] = mkv("sat_then_lit", 1, b8(0,0,0,0,0,9,0,0), 7,
                      b8(0,4,0,1,lit(9),0,2,0), 1, 0, -1, 0);
        vecs[5] = mkv("all_zero", 0, b8(0,0,0,0,0,0,0,0), 2,
                      b8(0,8,0,0,0,0,0,0), 1, 0, -1, 0);
        vecs[6] = mkv("sat_boundary", 1, b8(0,0,0,0,6,0,0,0), 5,
                      b8(0,4,lit(6),0,3,0,0,0), 1, 0, -1, 0);
        vecs[7] = mkv("stall_cnt", 0, b8(0,0,5,0,0,0,0,0), 5,
                      b8(0,2,lit(5),0,5,0,0,0), 1, 0, 2, 2);
        vecs[8] = mkv("idle_resume", 0, b8(7,0,0,0,0,0,0,0), 3,
                      b8(lit(7),0,7,0,0,0,0,0), 1, 10, -1, 0);
        post_rst = mkv("after_rst", 0, b8(2,0,0,0,0,0,0,0), 3,
                       b8(lit(2),0,7,0,0,0,0,0), 1, 0, -1, 0);

        rst = 1'b1; sel = 1'b0; in_avail = 1'b0; in_data = 8'd0; out_full = 1'b0;
        repeat (2) @(posedge clk); #1;
        in_avail = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        check("rst in_read",    int'(rd_a), 0);
        check("rst out_write",  int'(ow_a), 0);
        check("rst out_data",   int'(od_a), 0);
        check("rst frame_done", int'(fd_a), 0);
        check("rst running a",  int'(run_a), 1);
        check("rst running b",  int'(run_b), 1);
        @(posedge clk); #1;
        in_avail = 1'b0;
        in_data  = 8'd0;
        rst      = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_frame(vecs[i]);

        // Reset in the middle of an open zero run.
        sel    = 1'b0;
        base_t = tok_q.size();
        base_d = done_cnt;
        repeat (3) send_pixel(8'd0);
        repeat (4) @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_abort token count", tok_q.size() - base_t, 1);
        check("rst_abort marker", (tok_q.size() > base_t) ? int'(tok_q[base_t]) : -1, 0);
        check("rst_abort frame_done", done_cnt - base_d, 0);
        run_frame(post_rst);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
